// File: rtl/controle_barramento.sv
// controle_barramento: bus master / arbiter for the shared 16-bit Barramento.
//
// Grants one requesting unit at a time in round-robin order and drives the
// per-port 2-bit control codes (bit 1 = escrever, bit 0 = ler) on the source
// and destination for HOLD_CYCLES cycles. It then spends one turnaround cycle
// with all codes idle while acknowledging the source. Requests whose
// destination is invalid are acknowledged with err and no bus activity.
//
// Optional feature: define BARRAMENTO_BROADCAST_EN to accept dest = 7 as a
// broadcast (source writes, every other port reads). Without it, dest = 7 is
// rejected like dest = 6.
//
// Parameters:
//   HOLD_CYCLES  cycles the codes stay asserted per transfer (1..2^CNT_W-1)
//   CNT_W        width of the hold counter
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   req_wr[5:0]      bit i: port i wants to write onto the bus
//   dest[17:0]       destination of port i in bits [3i+2:3i]
//   ctrl_0..ctrl_5   per-port bus code: 00 idle, 10 escrever, 01 ler
//   ack[5:0]         one-cycle pulse to the served source
//   err              one-cycle pulse with ack when the request was rejected
//   busy             high whenever the arbiter is not idle
module controle_barramento #(
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  req_wr,
  input  logic [17:0] dest,
  output logic [1:0]  ctrl_0,
  output logic [1:0]  ctrl_1,
  output logic [1:0]  ctrl_2,
  output logic [1:0]  ctrl_3,
  output logic [1:0]  ctrl_4,
  output logic [1:0]  ctrl_5,
  output logic [5:0]  ack,
  output logic        err,
  output logic        busy
);

  localparam int unsigned NPORTS = 6;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned SCAN_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    TRANSFER,
    RELEASE
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  src;
  logic [CNT_W-1:0]  cnt;
  logic [NPORTS-1:0] wr_en;
  logic [NPORTS-1:0] rd_en;

  // Per-port destination fields.
  logic [IDX_W-1:0] dest_arr [NPORTS];

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      dest_arr[i] = dest[3*i +: 3];
    end
  end

  // Round-robin pick: first requester scanning ptr, ptr+1, ... wrapping 5->0.
  logic              found;
  logic [IDX_W-1:0]  win_src;
  logic [IDX_W-1:0]  win_dst;
  logic [SCAN_W-1:0] scan;

  always_comb begin
    found   = 1'b0;
    win_src = '0;
    win_dst = '0;
    scan    = '0;
    for (int k = 0; k < NPORTS; k++) begin
      scan = {1'b0, ptr} + SCAN_W'(k);
      if (scan >= SCAN_W'(NPORTS)) begin
        scan = scan - SCAN_W'(NPORTS);
      end
      if (!found && req_wr[scan[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_src = scan[IDX_W-1:0];
        win_dst = dest_arr[scan[IDX_W-1:0]];
      end
    end
  end

  // Destination check and the code masks for the winning request.
  logic              dst_bcast;
  logic              dst_ok;
  logic [NPORTS-1:0] src_oh;
  logic [NPORTS-1:0] rd_mask;

  always_comb begin
    dst_bcast = 1'b0;
`ifdef BARRAMENTO_BROADCAST_EN
    dst_bcast = (win_dst == 3'd7);
`endif
    dst_ok  = dst_bcast || ((win_dst < 3'd6) && (win_dst != win_src));
    src_oh  = NPORTS'(1) << win_src;
    rd_mask = dst_bcast ? ~src_oh : (NPORTS'(1) << win_dst);
  end

  // Arbiter FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      src   <= '0;
      cnt   <= '0;
      wr_en <= '0;
      rd_en <= '0;
      ack   <= '0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      // ack/err are single-cycle pulses unless set below.
      ack <= '0;
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            src  <= win_src;
            busy <= 1'b1;
            if (dst_ok) begin
              wr_en <= src_oh;
              rd_en <= rd_mask;
              cnt   <= CNT_W'(HOLD_CYCLES - 1);
              state <= TRANSFER;
            end else begin
              ack   <= src_oh;
              err   <= 1'b1;
              state <= RELEASE;
            end
          end
        end
        TRANSFER: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Codes drop together with ack: this is the turnaround cycle.
            wr_en <= '0;
            rd_en <= '0;
            ack   <= NPORTS'(1) << src;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          ptr   <= (src == IDX_W'(NPORTS - 1)) ? '0 : src + IDX_W'(1);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ctrl_0 = {wr_en[0], rd_en[0]};
  assign ctrl_1 = {wr_en[1], rd_en[1]};
  assign ctrl_2 = {wr_en[2], rd_en[2]};
  assign ctrl_3 = {wr_en[3], rd_en[3]};
  assign ctrl_4 = {wr_en[4], rd_en[4]};
  assign ctrl_5 = {wr_en[5], rd_en[5]};

  // Bus safety: one writer at most, never writer and reader on one port.
  a_one_writer : assert property (@(posedge clk) disable iff (rst) $onehot0(wr_en));
  a_no_code_11 : assert property (@(posedge clk) disable iff (rst) (wr_en & rd_en) == '0);
  a_one_ack    : assert property (@(posedge clk) disable iff (rst) $onehot0(ack));

endmodule

// File: doc/controle_barramento.md
# controle_barramento

Bus master/arbiter that drives the 2-bit per-port control codes (`ctrl_0`..`ctrl_5`, bit 0 = ler, bit 1 = escrever) consumed by `Barramento`. Units raise write requests with a destination index. The block grants one source at a time in round-robin order and holds the write/read codes on source and destination for a fixed number of cycles. It then inserts a turnaround cycle and acknowledges the source. It sits between the processor's functional units (stack, registers, ALU ports) and the shared 16-bit bus.

## Interface
- `HOLD_CYCLES`, default 1: cycles the ctrl codes stay asserted per transfer (1..2^CNT_W-1).
- `CNT_W`, default 4: width of the hold counter.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_wr` input 6: bit i = port i requests to write onto the bus.
- `dest` input 18: destination of port i in bits [3i+2:3i]; values 0..5 are ports, 6 is invalid, 7 is broadcast (see Configuration).
- `ctrl_0`..`ctrl_5` output 2 each: per-port bus code, 00 idle, 10 escrever, 01 ler; 11 never driven.
- `ack` output 6: one-cycle pulse to the served source.
- `err` output 1: one-cycle pulse coincident with `ack` when the request was rejected.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, TRANSFER, RELEASE. All outputs are registered.
- **Reset** (`rst`=1 at an edge):
  - All `ctrl_*` = 00, `ack` = 0, `err` = 0, `busy` = 0.
  - Round-robin pointer `ptr` = 0, state = IDLE.
  - Reset wins over any in-progress transfer; the ctrl codes drop in the cycle after the reset edge.
- **IDLE:**
  - If `req_wr` = 0, stay in IDLE.
  - Otherwise the winner is the first set bit scanning `ptr`, `ptr+1`, …, wrapping at 5→0. Latch `src` and `dst` = `dest[src]`.
  - Valid `dst` (0..5 and ≠ `src`): `ctrl_src` <= 10, `ctrl_dst` <= 01, counter <= HOLD_CYCLES-1, state <= TRANSFER.
  - Invalid `dst` (6, `dst`==`src`, or 7 without broadcast): no ctrl driven, `ack[src]` <= 1, `err` <= 1, state <= RELEASE.
- **TRANSFER:**
  - Counter ≠ 0: decrement it and hold the codes.
  - Counter = 0: all `ctrl_*` <= 00, `ack[src]` <= 1, state <= RELEASE.
- **RELEASE:**
  - `ack`/`err` fall back to 0; `ptr` <= (`src`+1) mod 6.
  - State <= IDLE, unconditionally.
- **Requester contract:**
  - Hold `req_wr[i]` and `dest[i]` stable until `ack[i]` is seen.
  - Deassert `req_wr[i]` at the edge ending the `ack` cycle.
  - Deasserting early does not abort the transfer. Changes to `dest` after the grant are ignored.
- `ptr` advances only on a grant (valid or rejected), so every requesting port is served within 6 grants.

## Timing
- A request present in IDLE cycle t asserts ctrl codes in cycles t+1 .. t+HOLD_CYCLES.
- `ack` (and `err`, if rejected) is high in cycle t+HOLD_CYCLES+1, with all ctrl = 00 (bus turnaround).
- IDLE resumes in cycle t+HOLD_CYCLES+2, so back-to-back transfers have exactly 2 idle bus cycles between ctrl windows.
- Rejected request: `ack`/`err` in cycle t+1, IDLE in t+2.
- At most one `ctrl_*` is ever 10 in any cycle; a port is never both writer and reader.

## Configuration
- `BARRAMENTO_BROADCAST_EN` defined: `dest` = 7 is valid.
  - Source gets 10, every other port gets 01 for HOLD_CYCLES.
  - `ack`/`err` timing is unchanged (`err` = 0).
- Undefined: `dest` = 7 is treated like 6, i.e. rejected with `err`.

## Test plan
- Single transfer, HOLD_CYCLES=1:
  - Stimulus: `req_wr`=000100, `dest[2]`=4 at cycle 0.
  - Response: `ctrl_2`=10 and `ctrl_4`=01 in cycle 1 only; `ack`=000100 in cycle 2; `busy` high cycles 1–2.
- All six ports requesting, each with a valid distinct destination, starting from reset:
  - Grants occur in order 0,1,2,3,4,5, one every 3 cycles.
  - Each `ack` is a single pulse and no two ports ever show 10 simultaneously.
- Rejections:
  - Port 3 with `dest`=3: no ctrl activity, `ack[3]`=1 and `err`=1 in cycle 1.
  - Repeat with `dest`=6: same result.
- HOLD_CYCLES=3, port 0→5:
  - `ctrl_0`=10 and `ctrl_5`=01 for cycles 1–3, `ack[0]` in cycle 4.
  - Changing `dest[0]` in cycle 2 has no effect.
- Broadcast, port 1 `dest`=7:
  - With `BARRAMENTO_BROADCAST_EN`: `ctrl_1`=10, all others 01, `err`=0.
  - Without it: no ctrl activity, `err`=1.
- Reset mid-transfer:
  - `rst` asserted in cycle 2 of a HOLD_CYCLES=3 transfer.
  - Cycle 3: all ctrl = 00, no `ack`, `busy`=0.
  - Next grant starts scanning from port 0.
